// File: rtl/spdif_tx_cs.sv
// spdif_tx_cs: IEC 60958 consumer S/PDIF transmitter with 192-frame
// channel-status blocks, underrun signalling and block-start marker.
module spdif_tx_cs #(
    parameter int WIDTH    = 24,
    parameter int ACC_W    = 16,
    parameter int ACC_STEP = 16026
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] audio_l,
    input  logic [WIDTH-1:0] audio_r,
    input  logic             valid,
    output logic             ack,
    input  logic [23:0]      cs_cfg,
    output logic             spdif,
    output logic             spdif_tick,
    output logic             block_start,
    output logic             underrun
);

    localparam logic [7:0] PRE_B = 8'b11101000;
    localparam logic [7:0] PRE_M = 8'b11100010;
    localparam logic [7:0] PRE_W = 8'b11100100;

    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   acc_sum;
    logic [6:0]       hb;
    logic [7:0]       frame;
    logic [WIDTH-1:0] smp_l;
    logic [WIDTH-1:0] smp_r;
    logic             v_bit;
    logic [23:0]      cs_q;
    logic             pre_lvl;

    logic             load;
    logic [5:0]       pos;
    logic [4:0]       slot;
    logic [23:0]      payload;
    logic [23:0]      pay_sh;
    logic [7:0]       pre;
    logic             c_bit;
    logic             par;
    logic             pre_bit;
    logic             data_bit;
    logic             spdif_nxt;

    assign acc_sum     = {1'b0, acc} + (ACC_W+1)'(ACC_STEP);
    assign spdif_tick  = acc_sum[ACC_W];
    assign load        = spdif_tick && (hb == 7'd0);
    assign ack         = load && valid;
    assign underrun    = load && !valid;
    assign block_start = load && (frame == 8'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            hb      <= '0;
            frame   <= '0;
            smp_l   <= '0;
            smp_r   <= '0;
            v_bit   <= 1'b0;
            cs_q    <= '0;
            pre_lvl <= 1'b0;
            spdif   <= 1'b0;
        end else begin
            acc <= acc_sum[ACC_W-1:0];
            if (spdif_tick) begin
                hb    <= hb + 7'd1;
                spdif <= spdif_nxt;
                if (hb == 7'd127)
                    frame <= (frame == 8'd191) ? 8'd0 : frame + 8'd1;
                if (pos == 6'd0)
                    pre_lvl <= spdif;
            end
            if (load) begin
                smp_l <= valid ? audio_l : '0;
                smp_r <= valid ? audio_r : '0;
                v_bit <= !valid;
                if (frame == 8'd0)
                    cs_q <= cs_cfg;
            end
        end
    end

    // Samples are MSB-aligned to slot 27; unused low slots stay zero.
    always_comb begin
        pos      = hb[5:0];
        slot     = pos[5:1];
        payload  = 24'(hb[6] ? smp_r : smp_l) << (24 - WIDTH);
        pay_sh   = payload >> (slot - 5'd4);
        c_bit    = (frame < 8'd24) ? cs_q[frame[4:0]] : 1'b0;
        par      = ^{payload, v_bit, c_bit};
        pre      = hb[6] ? PRE_W : ((frame == 8'd0) ? PRE_B : PRE_M);
        pre_bit  = pre[~pos[2:0]] ^ ((pos == 6'd0) ? spdif : pre_lvl);
        data_bit = pay_sh[0];
        unique case (1'b1)
            (slot == 5'd28): data_bit = v_bit;
            (slot == 5'd29): data_bit = 1'b0;
            (slot == 5'd30): data_bit = c_bit;
            (slot == 5'd31): data_bit = par;
            default:         data_bit = pay_sh[0];
        endcase
        if (slot < 5'd4)
            spdif_nxt = pre_bit;
        else if (!pos[0])
            spdif_nxt = !spdif;
        else
            spdif_nxt = data_bit ? !spdif : spdif;
    end

endmodule

// File: tb/tb_spdif_tx_cs.sv
// tb_spdif_tx_cs: scoreboard bench decoding the BMC line of a
// 24-bit and a 16-bit transmitter driven from the same source.
module tb_spdif_tx_cs;

    localparam int STEP = 40000;
    localparam logic [7:0] PB = 8'b11101000;
    localparam logic [7:0] PM = 8'b11100010;
    localparam logic [7:0] PW = 8'b11100100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] audio_l = '0;
    logic [23:0] audio_r = '0;
    logic [23:0] cs_cfg = '0;
    logic        valid = 1'b0;

    logic ack_a, spdif_a, tick_a, bs_a, und_a;
    logic ack_b, spdif_b, tick_b, bs_b, und_b;

    always #5 clk = ~clk;

    spdif_tx_cs #(.WIDTH(24), .ACC_W(16), .ACC_STEP(STEP)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .audio_l(audio_l), .audio_r(audio_r), .valid(valid),
        .ack(ack_a), .cs_cfg(cs_cfg), .spdif(spdif_a),
        .spdif_tick(tick_a), .block_start(bs_a), .underrun(und_a)
    );

    spdif_tx_cs #(.WIDTH(16), .ACC_W(16), .ACC_STEP(STEP)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .audio_l(audio_l[15:0]), .audio_r(audio_r[15:0]), .valid(valid),
        .ack(ack_b), .cs_cfg(cs_cfg), .spdif(spdif_b),
        .spdif_tick(tick_b), .block_start(bs_b), .underrun(und_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [7:0]  pre;
        logic [23:0] d24;
        logic [23:0] d16;
        logic        v;
        logic        c;
    } exp_t;

    typedef struct packed {
        logic [7:0]  pre;
        logic [23:0] data;
        logic        v;
        logic        u;
        logic        c;
        logic        par_ok;
        logic        bmc_ok;
    } dec_t;

    function automatic dec_t decode(input logic [63:0] h, input logic lv);
        dec_t d;
        logic bit_v;
        logic par;
        d = '0;
        par = 1'b0;
        d.bmc_ok = 1'b1;
        for (int i = 0; i < 8; i++)
            d.pre[7-i] = h[i] ^ lv;
        for (int s = 4; s < 32; s++) begin
            if (h[2*s] == h[2*s-1])
                d.bmc_ok = 1'b0;
            bit_v = h[2*s] ^ h[2*s+1];
            par ^= bit_v;
            if (s < 28)
                d.data[s-4] = bit_v;
            else if (s == 28)
                d.v = bit_v;
            else if (s == 29)
                d.u = bit_v;
            else if (s == 30)
                d.c = bit_v;
        end
        d.par_ok = !par;
        return d;
    endfunction

    exp_t        q[$];
    logic [15:0] accm;
    logic        tick_m;
    logic        prev_tick;
    int          hb_m, fr_m, kcap;
    int          loads = 0;
    int          tks_ack, fr_bs;
    logic [23:0] cs_m;
    logic [63:0] hbuf [2];
    logic        lvl [2];

    task automatic check_subframe();
        exp_t e;
        dec_t d;
        if (q.size() == 0) begin
            chk("queue_empty", 64'd1, 64'd0);
            return;
        end
        e = q.pop_front();
        for (int s = 0; s < 2; s++) begin
            d = decode(hbuf[s], lvl[s]);
            lvl[s] = hbuf[s][63];
            chk(s ? "pre16" : "pre24", d.pre, e.pre);
            chk(s ? "data16" : "data24", d.data, s ? e.d16 : e.d24);
            chk(s ? "v16" : "v24", d.v, e.v);
            chk(s ? "u16" : "u24", d.u, 1'b0);
            chk(s ? "c16" : "c24", d.c, e.c);
            chk(s ? "par16" : "par24", d.par_ok, 1'b1);
            chk(s ? "bmc16" : "bmc24", d.bmc_ok, 1'b1);
        end
    endtask

    // Independent model of tick timing, counters and expected frames.
    always @(negedge clk) begin
        logic ld;
        logic cb;
        if (!rst_n) begin
            accm = '0; hb_m = 0; fr_m = 0; kcap = 0;
            prev_tick = 1'b0; cs_m = '0;
            lvl[0] = 1'b0; lvl[1] = 1'b0;
            tks_ack = -1; fr_bs = -1;
            q.delete();
        end else begin
            if (prev_tick) begin
                hbuf[0][kcap] = spdif_a;
                hbuf[1][kcap] = spdif_b;
                kcap++;
                if (kcap == 64) begin
                    check_subframe();
                    kcap = 0;
                end
            end
            accm = accm + 16'(STEP);
            tick_m = ({1'b0, accm} + 17'(STEP)) >= 17'h10000;
            chk("tick", {tick_a, tick_b}, {tick_m, tick_m});
            ld = tick_m && (hb_m == 0);
            if (ld) begin
                if (fr_m == 0)
                    cs_m = cs_cfg;
                cb = (fr_m < 24) ? cs_m[fr_m] : 1'b0;
                q.push_back('{(fr_m == 0) ? PB : PM,
                              valid ? audio_l : 24'h0,
                              valid ? {audio_l[15:0], 8'h00} : 24'h0,
                              !valid, cb});
                q.push_back('{PW,
                              valid ? audio_r : 24'h0,
                              valid ? {audio_r[15:0], 8'h00} : 24'h0,
                              !valid, cb});
                if (valid && tks_ack >= 0)
                    chk("ack_gap", tks_ack, 128);
                tks_ack = valid ? 0 : -1;
                if (fr_m == 0) begin
                    if (fr_bs >= 0)
                        chk("bs_gap", fr_bs, 192);
                    fr_bs = 0;
                end
                chk("pulses",
                    {ack_a, und_a, bs_a, ack_b, und_b, bs_b},
                    {valid, !valid, fr_m == 0, valid, !valid, fr_m == 0});
                loads++;
            end else begin
                chk("pulses",
                    {ack_a, und_a, bs_a, ack_b, und_b, bs_b}, 6'd0);
            end
            if (tick_m) begin
                if (tks_ack >= 0)
                    tks_ack++;
                hb_m = (hb_m + 1) % 128;
                if (hb_m == 0) begin
                    fr_m = (fr_m + 1) % 192;
                    if (fr_bs >= 0)
                        fr_bs++;
                end
            end
            prev_tick = tick_m;
        end
    end

    logic abort = 1'b0;

    task automatic wait_loads(input int target);
        int t = 0;
        while (loads < target && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (loads < target) begin
            chk("wait_load", 64'(loads), 64'(target));
            abort = 1'b1;
        end
    endtask

    task automatic check_idle();
        chk("rst_out",
            {spdif_a, tick_a, ack_a, bs_a, und_a,
             spdif_b, tick_b, ack_b, bs_b, und_b}, 10'd0);
    endtask

    initial begin
        int base;
        repeat (3) @(negedge clk);
        check_idle();
        valid   = 1'b1;
        audio_l = 24'h800001;
        audio_r = 24'h7FFFFF;
        cs_cfg  = 24'h000004;
        #2 rst_n = 1'b1;
        for (int n = 0; n < 200; n++) begin
            wait_loads(n + 1);
            if (abort)
                break;
            @(posedge clk);
            #1;
            valid = 1'b1;
            case (n + 1)
                1: begin audio_l = 24'h00A5A5; audio_r = 24'h123456; end
                2: valid = 1'b0;
                3: begin audio_l = 24'hFFFFFF; audio_r = 24'h000000; end
                default: begin
                    audio_l = {n[7:0], 8'hC3 ^ n[7:0], n[7:0] + 8'd17};
                    audio_r = audio_l ^ 24'h0F0F0F;
                end
            endcase
            if (n + 1 == 100)
                cs_cfg = 24'h000010;
        end
        if (!abort) begin
            wait_loads(201);
            repeat (40) @(negedge clk);
            #2 rst_n = 1'b0;
            @(negedge clk);
            check_idle();
            audio_l = 24'h135799;
            audio_r = 24'hFEDCBA;
            valid   = 1'b1;
            @(negedge clk);
            #2 rst_n = 1'b1;
            base = loads;
            wait_loads(base + 4);
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
